// File: rtl/sd_decimator_prog_if.sv
// Sample-in / decimated-out handshake bundle for the sigma-delta decimator.
interface sd_decimator_prog_if #(
  parameter int IN_W  = 48,
  parameter int OUT_W = 32
) ();
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  modport master (output in_valid, in_data, out_ready,
                  input  out_valid, out_data, out_sat);
  modport slave  (input  in_valid, in_data, out_ready,
                  output out_valid, out_data, out_sat);
endinterface

// File: rtl/sd_decimator_prog.sv
// Accumulate-and-dump decimator with programmable ratio/shift, round-half-up,
// saturation and a small output FIFO with sticky overrun reporting.
module sd_decimator_prog #(
  parameter int IN_W       = 48,
  parameter int ACC_W      = 64,
  parameter int OUT_W      = 32,
  parameter int RATIO_W    = 10,
  parameter int SHIFT_W    = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_enable,
  input  logic [RATIO_W-1:0]   cfg_ratio,
  input  logic [SHIFT_W-1:0]   cfg_shift,
  sd_decimator_prog_if.slave   bus,
  output logic                 overrun,
  input  logic                 clr_overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [ACC_W:0] MAX_W = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_W = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] sum,
                                                        input logic [SHIFT_W-1:0] s);
    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] half;
    wide = {sum[ACC_W-1], sum};
    half = (s == '0) ? '0 : ({{ACC_W{1'b0}}, 1'b1} << (s - SHIFT_W'(1)));
    return (wide + half) >>> s;
  endfunction

  // Returns {sat, data}.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] r);
    if (r > MAX_W)      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    else if (r < MIN_W) return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else                return {1'b0, r[OUT_W-1:0]};
  endfunction

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   sample_ext;
  logic signed [ACC_W-1:0]   sum_next;
  logic [RATIO_W-1:0]        count;
  logic [RATIO_W-1:0]        ratio_q;
  logic [RATIO_W-1:0]        eff_ratio;
  logic [SHIFT_W-1:0]        shift_q;
  logic                      dump;

  assign sample_ext = {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
  assign sum_next   = acc + sample_ext;
  assign eff_ratio  = (cfg_ratio == '0) ? RATIO_W'(1) : cfg_ratio;
  assign dump       = (state == RUN) && cfg_enable && bus.in_valid &&
                      (count == ratio_q - RATIO_W'(1));

  logic signed [ACC_W-1:0]   sum_p1;
  logic [SHIFT_W-1:0]        shift_p1;
  logic                      vld_p1;
  logic signed [OUT_W-1:0]   data_p2;
  logic                      sat_p2;
  logic                      vld_p2;

  // Accumulate stage: FSM, frame counter and config latch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      ratio_q <= RATIO_W'(1);
      shift_q <= '0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      vld_p1 <= dump;
      vld_p2 <= vld_p1;
      case (state)
        IDLE: begin
          acc   <= '0;
          count <= '0;
          if (cfg_enable) begin
            state   <= RUN;
            ratio_q <= eff_ratio;
            shift_q <= cfg_shift;
          end
        end
        RUN: begin
          if (!cfg_enable) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
          end else if (dump) begin
            acc     <= '0;
            count   <= '0;
            ratio_q <= eff_ratio;
            shift_q <= cfg_shift;
          end else if (bus.in_valid) begin
            acc   <= sum_next;
            count <= count + RATIO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // P1 holds the frame sum with the shift it was framed under; P2 holds the rounded result
  always_ff @(posedge clk) begin
    if (dump) begin
      sum_p1   <= sum_next;
      shift_p1 <= shift_q;
    end
    if (vld_p1) {sat_p2, data_p2} <= saturate(round_shift(sum_p1, shift_p1));
  end

  logic [OUT_W:0] mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [OUT_W:0] head;
  logic           empty;
  logic           full;
  logic           pop;
  logic           push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && bus.out_ready;
  assign push  = vld_p2 && (!full || pop);
  assign head  = mem[rd_ptr[AW-1:0]];

  // FIFO stage: a push into a full FIFO only succeeds when the head leaves the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (vld_p2 && !push) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {sat_p2, data_p2};
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : head[OUT_W-1:0];
  assign bus.out_sat   = !empty && head[OUT_W];
endmodule
